l2_i_responder: RTL and testbench

- L2-side responder for L1 instruction-cache refill requests.
- Accepts a read request (tag/index) from the L1 I-cache controller and looks it up in an internal 2-way L2 tag store.
- On an L2 miss, fetches the block from main memory and refills the tag store.
- Signals completion to L1 with a one-cycle ready pulse, and drives way/index/refill controls to the external L2 data array.

---
 rtl/l2_i_responder_if.sv | 36 +++
 rtl/l2_i_responder.sv | 215 +++++++++++++++++++++
 tb/tb_l2_i_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_i_responder_if.sv
// l2_i_responder_if: bundles the L1 request channel, the L2 data-array
// controls and the main-memory read channel of the L2 I-side responder.
// The slave modport is the responder; the master modport is the
// environment (L1 controller, memory, data array).
interface l2_i_responder_if #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8
) ();
  // L1 request channel
  logic              read_L1_L2;
  logic [TNUM_2-1:0] tag_L1_L2;
  logic [INUM_2-1:0] index_L1_L2;
  logic              flush;
  logic              ready_L2_L1;
  // L2 data-array controls
  logic              way_L2;
  logic [INUM_2-1:0] index_L2;
  logic              refill_L2;
  // Main-memory read channel
  logic              read_L2_MEM;
  logic [TNUM_2-1:0] tag_L2_MEM;
  logic [INUM_2-1:0] index_L2_MEM;
  logic              ready_MEM_L2;

  modport slave (
    input  read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    output ready_L2_L1, way_L2, index_L2, refill_L2,
           read_L2_MEM, tag_L2_MEM, index_L2_MEM
  );

  modport master (
    output read_L1_L2, tag_L1_L2, index_L1_L2, flush, ready_MEM_L2,
    input  ready_L2_L1, way_L2, index_L2, refill_L2,
           read_L2_MEM, tag_L2_MEM, index_L2_MEM
  );
endinterface

// File: rtl/l2_i_responder.sv
// l2_i_responder: L2-side responder for L1 instruction-cache refills.
// Looks the requested block up in a 2-way tag store (valid/tag per way,
// one LRU bit per set), fetches from memory on a miss, refills the tag
// store and pulses ready_L2_L1 to the L1 controller.
// Optional feature macro: L2_I_RESPONDER_STAT_EN adds saturating
// hit_count / miss_count outputs.
module l2_i_responder #(
  parameter int TNUM_2  = 18,
  parameter int INUM_2  = 8,
  parameter int HIT_LAT = 2   // lookup latency, 1..15 cycles
) (
  input  logic clk,
  input  logic nrst,
`ifdef L2_I_RESPONDER_STAT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  l2_i_responder_if.slave bus
);

  localparam int NSETS = 1 << INUM_2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TNUM_2-1:0] tag_q, tag_d;          // captured request tag
  logic [INUM_2-1:0] idx_q, idx_d;          // captured request index
  logic [NSETS-1:0]  valid0_q, valid0_d;
  logic [NSETS-1:0]  valid1_q, valid1_d;
  logic [NSETS-1:0]  lru_q, lru_d;          // way to evict next
  logic              flush_pend_q, flush_pend_d;

  logic              ready_q, ready_d;
  logic              refill_q, refill_d;
  logic              read_mem_q, read_mem_d;
  logic              way_q, way_d;          // hit way or victim way
  logic [INUM_2-1:0] index_l2_q, index_l2_d;
  logic [TNUM_2-1:0] mem_tag_q, mem_tag_d;
  logic [INUM_2-1:0] mem_idx_q, mem_idx_d;

  logic [TNUM_2-1:0] tag0_mem [NSETS];
  logic [TNUM_2-1:0] tag1_mem [NSETS];

  logic hit0, hit1, lookup_hit, lookup_done, victim, tag_we;

  // Tag compare and victim choice for the captured set.
  assign hit0        = valid0_q[idx_q] && (tag0_mem[idx_q] == tag_q);
  assign hit1        = valid1_q[idx_q] && (tag1_mem[idx_q] == tag_q);
  assign lookup_hit  = hit0 || hit1;
  assign lookup_done = (state_q == LOOKUP) && (cnt_q == 4'(HIT_LAT));
  assign victim      = !valid0_q[idx_q] ? 1'b0 :
                       !valid1_q[idx_q] ? 1'b1 : lru_q[idx_q];

  // Next-state and next-output computation for the responder FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    valid0_d     = valid0_q;
    valid1_d     = valid1_q;
    lru_d        = lru_q;
    flush_pend_d = flush_pend_q | bus.flush;
    ready_d      = 1'b0;
    refill_d     = 1'b0;
    read_mem_d   = read_mem_q;
    way_d        = way_q;
    index_l2_d   = index_l2_q;
    mem_tag_d    = mem_tag_q;
    mem_idx_d    = mem_idx_q;
    tag_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          // Flush wins over a same-cycle request; a held flush re-arms.
          valid0_d     = '0;
          valid1_d     = '0;
          lru_d        = '0;
          flush_pend_d = bus.flush;
        end else if (bus.read_L1_L2) begin
          tag_d   = bus.tag_L1_L2;
          idx_d   = bus.index_L1_L2;
          cnt_d   = 4'd1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_done) begin
          index_l2_d = idx_q;
          if (lookup_hit) begin
            way_d         = hit1 && !hit0;
            lru_d[idx_q]  = !(hit1 && !hit0);
            ready_d       = 1'b1;
            state_d       = RESP;
          end else begin
            way_d      = victim;
            read_mem_d = 1'b1;
            mem_tag_d  = tag_q;
            mem_idx_d  = idx_q;
            state_d    = MISS;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MISS: begin
        if (bus.ready_MEM_L2) begin
          read_mem_d = 1'b0;
          refill_d   = 1'b1;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        tag_we       = 1'b1;
        lru_d[idx_q] = !way_q;
        if (way_q) valid1_d[idx_q] = 1'b1;
        else       valid0_d[idx_q] = 1'b1;
        ready_d      = 1'b1;
        state_d      = RESP;
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      flush_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      refill_q     <= 1'b0;
      read_mem_q   <= 1'b0;
      way_q        <= 1'b0;
      index_l2_q   <= '0;
      mem_tag_q    <= '0;
      mem_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      lru_q        <= lru_d;
      flush_pend_q <= flush_pend_d;
      ready_q      <= ready_d;
      refill_q     <= refill_d;
      read_mem_q   <= read_mem_d;
      way_q        <= way_d;
      index_l2_q   <= index_l2_d;
      mem_tag_q    <= mem_tag_d;
      mem_idx_q    <= mem_idx_d;
    end
  end

  // Tag array write on refill exit.
  always_ff @(posedge clk) begin
    // NOTE: tag storage is not reset; the valid bits alone decide a hit.
    if (tag_we) begin
      if (way_q) tag1_mem[idx_q] <= tag_q;
      else       tag0_mem[idx_q] <= tag_q;
    end
  end

  assign bus.ready_L2_L1  = ready_q;
  assign bus.refill_L2    = refill_q;
  assign bus.way_L2       = way_q;
  assign bus.index_L2     = index_l2_q;
  assign bus.read_L2_MEM  = read_mem_q;
  assign bus.tag_L2_MEM   = mem_tag_q;
  assign bus.index_L2_MEM = mem_idx_q;

`ifdef L2_I_RESPONDER_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters, bumped at lookup exit; flush leaves them alone.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_done && lookup_hit && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (lookup_done && !lookup_hit && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter flops, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  // Statistics disabled: no counter state or ports.
`endif

endmodule

// File: tb/tb_l2_i_responder.sv
// tb_l2_i_responder: directed, table-driven bench for l2_i_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_l2_i_responder;

  localparam int HL = 2;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  l2_i_responder_if #(.TNUM_2(18), .INUM_2(8)) bus ();

`ifdef L2_I_RESPONDER_STAT_EN
  logic [31:0] hit_count, miss_count;
`endif

  l2_i_responder #(.TNUM_2(18), .INUM_2(8), .HIT_LAT(HL)) dut (
    .clk        (clk),
    .nrst       (nrst),
`ifdef L2_I_RESPONDER_STAT_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One L1 request from issue to the first idle cycle after HOLD.
  // k counts falling edges since the capture edge E0 (k=0 follows E0),
  // so a sample at k shows the state after edge E0+k.
  task automatic run_req(input logic [17:0] tag, input logic [7:0] idx,
                         input int delay, input int flush_k,
                         input bit exp_hit, input bit exp_way,
                         input string name);
    int k = -1;
    int rise_k = -1;
    int ready_k = -1;
    int ready_cnt = 0;
    int refill_cnt = 0;
    logic refill_way = 1'b0;
    logic ready_way = 1'b0;
    logic [7:0] ready_idx = '0;
    logic [17:0] mtag = '0;
    logic [7:0] midx = '0;
    bus.read_L1_L2  = 1'b1;
    bus.tag_L1_L2   = tag;
    bus.index_L1_L2 = idx;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      k++;
      bus.flush = (k == flush_k);
      if (bus.read_L2_MEM && rise_k < 0) begin
        rise_k = k;
        mtag   = bus.tag_L2_MEM;
        midx   = bus.index_L2_MEM;
      end
      bus.ready_MEM_L2 = (rise_k >= 0) && (k == rise_k + delay - 1);
      if (bus.refill_L2) begin
        refill_cnt++;
        refill_way = bus.way_L2;
      end
      if (bus.ready_L2_L1) begin
        ready_cnt++;
        if (ready_k < 0) begin
          ready_k   = k;
          ready_way = bus.way_L2;
          ready_idx = bus.index_L2;
          bus.read_L1_L2 = 1'b0;
        end
      end
      if (ready_k >= 0 && k == ready_k + 2) break;
    end
    bus.flush        = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    if (ready_k < 0) begin
      n_total++;
      $display("FAIL %s timeout: no ready_L2_L1 within 300 cycles", name);
      bus.read_L1_L2 = 1'b0;
    end else begin
      // Hit: ready after E0+HL. Miss: memory request at E0+HL, Em one cycle
      // before the delay-th cycle of it, ready two cycles after Em.
      check({name, " ready latency"}, ready_k, exp_hit ? HL : HL + delay + 1);
      check({name, " ready pulses"}, ready_cnt, 1);
      check({name, " way at ready"}, ready_way, exp_way);
      check({name, " index_L2"}, ready_idx, idx);
      check({name, " mem rise"}, rise_k, exp_hit ? -1 : HL);
      check({name, " refill pulses"}, refill_cnt, exp_hit ? 0 : 1);
      if (!exp_hit) begin
        check({name, " tag_L2_MEM"}, mtag, tag);
        check({name, " index_L2_MEM"}, midx, idx);
        check({name, " refill way"}, refill_way, exp_way);
      end
    end
  endtask

  typedef struct {
    logic [17:0] tag;
    logic [7:0]  idx;
    int          delay;
    bit          hit;
    bit          way;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   busy;
    bit   seen;
    // Set 5 walks through fill, hit, second fill, LRU eviction.
    // Way/LRU trace for set 5: ABC->w0 (lru=1), hit w0, DEF->w1 (lru=0),
    // 1234 evicts w0 (lru=1), DEF hits w1 (lru=0), ABC evicts 1234 in w0.
    vecs[0] = '{18'h00ABC, 8'h05, 5, 1'b0, 1'b0};
    vecs[1] = '{18'h00ABC, 8'h05, 0, 1'b1, 1'b0};
    vecs[2] = '{18'h00DEF, 8'h05, 3, 1'b0, 1'b1};
    vecs[3] = '{18'h01234, 8'h05, 4, 1'b0, 1'b0};
    vecs[4] = '{18'h00DEF, 8'h05, 0, 1'b1, 1'b1};
    vecs[5] = '{18'h00ABC, 8'h05, 2, 1'b0, 1'b0};
    // Extreme tag/index values, memory ready one cycle after the request.
    vecs[6] = '{18'h3FFFF, 8'hFF, 1, 1'b0, 1'b0};
    vecs[7] = '{18'h3FFFF, 8'hFF, 0, 1'b1, 1'b0};

    nrst             = 1'b0;
    bus.read_L1_L2   = 1'b0;
    bus.tag_L1_L2    = '0;
    bus.index_L1_L2  = '0;
    bus.flush        = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready_L2_L1", bus.ready_L2_L1, 0);
    check("reset refill_L2", bus.refill_L2, 0);
    check("reset read_L2_MEM", bus.read_L2_MEM, 0);
    check("reset way/index_L2", {bus.way_L2, bus.index_L2}, 0);
    check("reset mem tag/index", {bus.tag_L2_MEM, bus.index_L2_MEM}, 0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].tag, vecs[i].idx, vecs[i].delay, -1,
              vecs[i].hit, vecs[i].way, $sformatf("v%0d", i));
`ifdef L2_I_RESPONDER_STAT_EN
      if (i == 5) begin
        check("stat hit_count", hit_count, 2);
        check("stat miss_count", miss_count, 4);
      end
`endif
    end

    // Flush pulsed in MISS: set 5 has ABC w0, DEF w1, lru=1 -> BEE into w1.
    run_req(18'h00BEE, 8'h05, 4, 3, 1'b0, 1'b1, "flush-in-miss");
    repeat (2) @(negedge clk);
    run_req(18'h00ABC, 8'h05, 2, -1, 1'b0, 1'b0, "post-flush ABC");
    run_req(18'h3FFFF, 8'hFF, 2, -1, 1'b0, 1'b0, "post-flush FF");
    run_req(18'h00DEF, 8'h05, 2, -1, 1'b0, 1'b1, "fill DEF");

    // Reset while the memory read is outstanding.
    bus.read_L1_L2  = 1'b1;
    bus.tag_L1_L2   = 18'h00777;
    bus.index_L1_L2 = 8'h05;
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clk);
      if (bus.read_L2_MEM) seen = 1'b1;
    end
    check("rst-mid-miss reached MISS", seen, 1);
    nrst = 1'b0;
    bus.read_L1_L2 = 1'b0;
    @(negedge clk);
    check("rst-mid-miss read_L2_MEM", bus.read_L2_MEM, 0);
    check("rst-mid-miss pulses", {bus.ready_L2_L1, bus.refill_L2}, 0);
    check("rst-mid-miss way/index_L2", {bus.way_L2, bus.index_L2}, 0);
    check("rst-mid-miss mem tag/index", {bus.tag_L2_MEM, bus.index_L2_MEM}, 0);
    nrst = 1'b1;
    @(negedge clk);
    run_req(18'h00DEF, 8'h05, 3, -1, 1'b0, 1'b0, "post-rst DEF");

    // Held flush blocks requests; stray memory-ready is ignored.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.read_L1_L2   = 1'b1;
    bus.tag_L1_L2    = 18'h00DEF;
    bus.index_L1_L2  = 8'h05;
    bus.ready_MEM_L2 = 1'b1;
    busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.read_L2_MEM || bus.ready_L2_L1 || bus.refill_L2) busy++;
    end
    check("flush-hold activity", busy, 0);
    bus.flush        = 1'b0;
    bus.read_L1_L2   = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    repeat (3) @(negedge clk);
    run_req(18'h00DEF, 8'h05, 2, -1, 1'b0, 1'b0, "post-hold DEF");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
